// File: rtl/onedconv_pkg.sv
// Shared definitions for the 1-D convolution set-enable controller:
// FSM state encoding and default widths.
package onedconv_pkg;

  localparam int DEF_BITWIDTH_OF_COLUMS = 11;
  localparam int DEF_NUM_CH             = 4;
  localparam int DEF_BITWIDTH_OF_STRIDE = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/onedconv_stride_gate.sv
// Stride qualifier: accepts the first event of each group of str_lim events,
// counting the remaining events of the group down through the phase register.
module onedconv_stride_gate #(
  parameter int BITWIDTH_OF_STRIDE = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          evt,
  input  logic [BITWIDTH_OF_STRIDE-1:0] str_lim,
  output logic                          accept
);

  logic [BITWIDTH_OF_STRIDE-1:0] phase;
  logic                          reject;

  assign accept = evt & (phase == '0);
  assign reject = evt & (phase != '0);

  // Phase restarts at zero for each row so the first event is always taken.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase <= '0;
    end else if (accept) begin
      phase <= str_lim - BITWIDTH_OF_STRIDE'(1);
    end else if (reject) begin
      phase <= phase - BITWIDTH_OF_STRIDE'(1);
    end
  end

endmodule

// File: rtl/onedconv_set_ctrl.sv
// 1-D convolution set-enable controller with row-full handshake and per-channel clears.
// Optional skipped-event counter enabled by defining ONEDCONV_SET_CTRL_SKIP_CNT_EN.
module onedconv_set_ctrl
  import onedconv_pkg::*;
#(
  parameter int BITWIDTH_OF_COLUMS = DEF_BITWIDTH_OF_COLUMS,
  parameter int NUM_CH             = DEF_NUM_CH,
  parameter int BITWIDTH_OF_STRIDE = DEF_BITWIDTH_OF_STRIDE
) (
  input  logic                          ONEDCONV_SET_CTRL_clk,
  input  logic                          ONEDCONV_SET_CTRL_Rst,
  input  logic                          ONEDCONV_SET_CTRL_Start,
  input  logic                          ONEDCONV_SET_CTRL_En,
  input  logic                          ONEDCONV_SET_CTRL_Eqcw,
  input  logic                          ONEDCONV_SET_CTRL_Eqst,
  input  logic [NUM_CH-1:0]             ONEDCONV_SET_CTRL_Flag_Out_Full,
  input  logic [BITWIDTH_OF_COLUMS-1:0] ONEDCONV_SET_CTRL_Of_Colums,
  input  logic [BITWIDTH_OF_STRIDE-1:0] ONEDCONV_SET_CTRL_Stride,
  input  logic                          ONEDCONV_SET_CTRL_Done_Ack,
  output logic                          ONEDCONV_SET_CTRL_set_en,
  output logic [NUM_CH-1:0]             ONEDCONV_SET_CTRL_Rptclr,
  output logic [NUM_CH-1:0]             ONEDCONV_SET_CTRL_Oen_clr,
  output logic                          ONEDCONV_SET_CTRL_Flag_Om_Full,
  output logic                          ONEDCONV_SET_CTRL_Busy,
  output logic [BITWIDTH_OF_COLUMS-1:0] ONEDCONV_SET_CTRL_Skip_Count
);

  state_t                        state;
  logic [BITWIDTH_OF_COLUMS-1:0] col_cnt;
  logic [BITWIDTH_OF_COLUMS-1:0] col_lim;
  logic [BITWIDTH_OF_STRIDE-1:0] str_lim;
  logic                          evt;
  logic                          run_evt;
  logic                          start_take;
  logic                          accept;

  assign evt        = ONEDCONV_SET_CTRL_En & (ONEDCONV_SET_CTRL_Eqcw | ONEDCONV_SET_CTRL_Eqst);
  assign run_evt    = evt & (state == S_RUN) & (col_cnt != col_lim);
  assign start_take = ONEDCONV_SET_CTRL_Start & (state == S_IDLE);

  onedconv_stride_gate #(
    .BITWIDTH_OF_STRIDE (BITWIDTH_OF_STRIDE)
  ) u_stride_gate (
    .clk     (ONEDCONV_SET_CTRL_clk),
    .rst     (ONEDCONV_SET_CTRL_Rst),
    .clear   (start_take),
    .evt     (run_evt),
    .str_lim (str_lim),
    .accept  (accept)
  );

  // Row sequencing; the final accept issues its set_en while moving to DONE.
  always_ff @(posedge ONEDCONV_SET_CTRL_clk) begin
    if (ONEDCONV_SET_CTRL_Rst) begin
      state                          <= S_IDLE;
      col_cnt                        <= '0;
      col_lim                        <= '0;
      str_lim                        <= '0;
      ONEDCONV_SET_CTRL_set_en       <= 1'b0;
      ONEDCONV_SET_CTRL_Flag_Om_Full <= 1'b0;
      ONEDCONV_SET_CTRL_Busy         <= 1'b0;
    end else begin
      ONEDCONV_SET_CTRL_set_en       <= 1'b0;
      ONEDCONV_SET_CTRL_Flag_Om_Full <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ONEDCONV_SET_CTRL_Start) begin
            col_lim <= ONEDCONV_SET_CTRL_Of_Colums;
            str_lim <= (ONEDCONV_SET_CTRL_Stride == '0) ? BITWIDTH_OF_STRIDE'(1)
                                                          : ONEDCONV_SET_CTRL_Stride;
            col_cnt <= '0;
            if (ONEDCONV_SET_CTRL_Of_Colums == '0) begin
              state                  <= S_DONE;
              ONEDCONV_SET_CTRL_Busy <= 1'b0;
            end else begin
              state                  <= S_RUN;
              ONEDCONV_SET_CTRL_Busy <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            ONEDCONV_SET_CTRL_set_en <= 1'b1;
            col_cnt                  <= col_cnt + BITWIDTH_OF_COLUMS'(1);
            if (col_cnt + BITWIDTH_OF_COLUMS'(1) == col_lim) begin
              state                  <= S_DONE;
              ONEDCONV_SET_CTRL_Busy <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (ONEDCONV_SET_CTRL_Done_Ack) begin
            state   <= S_IDLE;
            col_cnt <= '0;
          end else begin
            ONEDCONV_SET_CTRL_Flag_Om_Full <= 1'b1;
          end
        end
        default: begin
          state                  <= S_IDLE;
          ONEDCONV_SET_CTRL_Busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ONEDCONV_SET_CTRL_clk) begin
    if (ONEDCONV_SET_CTRL_Rst) begin
      ONEDCONV_SET_CTRL_Rptclr  <= '1;
      ONEDCONV_SET_CTRL_Oen_clr <= '1;
    end else begin
      ONEDCONV_SET_CTRL_Rptclr  <= ~ONEDCONV_SET_CTRL_Flag_Out_Full;
      ONEDCONV_SET_CTRL_Oen_clr <= ~ONEDCONV_SET_CTRL_Flag_Out_Full;
    end
  end

`ifdef ONEDCONV_SET_CTRL_SKIP_CNT_EN
  logic reject;
  assign reject = run_evt & ~accept;

  always_ff @(posedge ONEDCONV_SET_CTRL_clk) begin
    if (ONEDCONV_SET_CTRL_Rst || start_take) begin
      ONEDCONV_SET_CTRL_Skip_Count <= '0;
    end else if (reject && (ONEDCONV_SET_CTRL_Skip_Count != '1)) begin
      ONEDCONV_SET_CTRL_Skip_Count <= ONEDCONV_SET_CTRL_Skip_Count + BITWIDTH_OF_COLUMS'(1);
    end
  end
`else
  assign ONEDCONV_SET_CTRL_Skip_Count = '0;
`endif

endmodule
